// File: rtl/nuc970_correct.sv
// Codeword error-correction stage: buffers one raw codeword, then XORs it with the
// decoder's error-mask stream, counting flipped bits and checking them against the decoder's count.
module nuc970_correct #(
    parameter int DATA_BITS = 4348,
    parameter int BITS      = 8,
    parameter int T         = 4
) (
    input  logic            clk_in,
    input  logic            rst_n,
    input  logic [BITS-1:0] data_in,
    input  logic            start_in,
    input  logic [BITS-1:0] err_in,
    input  logic            err_first_in,
    input  logic [7:0]      err_cnt_in,
    output logic [BITS-1:0] data_out,
    output logic            valid_out,
    output logic            first_out,
    output logic            last_out,
    output logic [7:0]      nerr_out,
    output logic            fail_out,
    output logic            busy_out,
    output logic            proto_err_out
);

    localparam int W   = (DATA_BITS + BITS - 1) / BITS;
    localparam int PAD = W * BITS - DATA_BITS;
    localparam int PW  = (W > 1) ? $clog2(W) : 1;
    localparam logic [BITS-1:0] FULL_MASK = {BITS{1'b1}};
    localparam logic [BITS-1:0] LAST_MASK = FULL_MASK << PAD;
    localparam logic [PW-1:0]   LAST_IDX  = PW'(W - 1);
    localparam logic [7:0]      T_LIM     = 8'(T);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CORRECT = 2'd3
    } state_t;

    function automatic logic [7:0] popcount(input logic [BITS-1:0] v);
        logic [7:0] p;
        p = 8'd0;
        for (int i = 0; i < BITS; i++) begin
            p = p + {7'd0, v[i]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      acc_q, acc_d;
    logic            proto_q, proto_d;
    logic [BITS-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic [7:0]      nerr_q, nerr_d;
    logic            fail_q, fail_d;

    logic [BITS-1:0] mem [W];
    logic [BITS-1:0] rdata_q;
    logic            we_s;
    logic [PW-1:0]   waddr_s;
    logic [PW-1:0]   raddr_s;
    logic            proc_s;
    logic [PW-1:0]   idx_s;
    logic [BITS-1:0] mask_s;
    logic [BITS-1:0] err_m_s;
    logic [7:0]      acc_base_s;

    // Next-state, buffer addressing and correction datapath.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        proto_d    = proto_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        first_d    = 1'b0;
        last_d     = 1'b0;
        nerr_d     = nerr_q;
        fail_d     = fail_q;
        we_s       = 1'b0;
        waddr_s    = wptr_q;
        raddr_s    = '0;
        proc_s     = 1'b0;
        idx_s      = rptr_q;
        mask_s     = FULL_MASK;
        err_m_s    = '0;
        acc_base_s = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    we_s    = 1'b1;
                    waddr_s = '0;
                    wptr_d  = PW'(1);
                    state_d = ST_CAPTURE;
                end else begin
                    state_d = ST_IDLE;
                end
                if (err_first_in) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            ST_CAPTURE: begin
                we_s = 1'b1;
                if (wptr_q == LAST_IDX) begin
                    state_d = ST_WAIT;
                end else begin
                    wptr_d = wptr_q + PW'(1);
                end
                if (start_in || err_first_in) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            ST_WAIT: begin
                if (err_first_in) begin
                    // Word 0 of the error stream rides with err_first_in.
                    cnt_d      = err_cnt_in;
                    acc_base_s = 8'd0;
                    proc_s     = 1'b1;
                    idx_s      = '0;
                    first_d    = 1'b1;
                    rptr_d     = PW'(1);
                    state_d    = ST_CORRECT;
                end else begin
                    state_d = ST_WAIT;
                end
                if (start_in) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            ST_CORRECT: begin
                proc_s = 1'b1;
                idx_s  = rptr_q;
                if (start_in || err_first_in) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (proc_s) begin
            if (idx_s == LAST_IDX) begin
                mask_s  = LAST_MASK;
                raddr_s = '0;
                last_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                mask_s  = FULL_MASK;
                raddr_s = idx_s + PW'(1);
                rptr_d  = idx_s + PW'(1);
            end
            err_m_s = err_in & mask_s;
            data_d  = (rdata_q ^ err_in) & mask_s;
            valid_d = 1'b1;
            acc_d   = sat_add(acc_base_s, popcount(err_m_s));
            if (last_d) begin
                nerr_d = acc_d;
                fail_d = (acc_d != cnt_d) || (cnt_d > T_LIM);
            end else begin
                nerr_d = nerr_q;
                fail_d = fail_q;
            end
        end else begin
            err_m_s = '0;
        end
    end

    // Codeword buffer with registered read port; contents deliberately survive reset.
    always_ff @(posedge clk_in) begin
        if (we_s) begin
            mem[waddr_s] <= data_in;
        end
        rdata_q <= mem[raddr_s];
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= 8'd0;
            acc_q   <= 8'd0;
            proto_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            nerr_q  <= 8'd0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            proto_q <= proto_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            nerr_q  <= nerr_d;
            fail_q  <= fail_d;
        end
    end

    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign first_out     = first_q;
    assign last_out      = last_q;
    assign nerr_out      = nerr_q;
    assign fail_out      = fail_q;
    assign busy_out      = (state_q != ST_IDLE);
    assign proto_err_out = proto_q;

endmodule

// File: tb/tb_nuc970_correct.sv
// Directed + randomized bench for nuc970_correct with a bit-level reference model of the corrected stream.
module tb_nuc970_correct;
    localparam int DATA_BITS = 4348;
    localparam int BITS      = 8;
    localparam int T         = 4;
    localparam int W         = (DATA_BITS + BITS - 1) / BITS;

    logic            clk_in = 1'b0;
    logic            rst_n = 1'b0;
    logic [BITS-1:0] data_in = '0;
    logic            start_in = 1'b0;
    logic [BITS-1:0] err_in = '0;
    logic            err_first_in = 1'b0;
    logic [7:0]      err_cnt_in = 8'd0;
    logic [BITS-1:0] data_out;
    logic            valid_out, first_out, last_out;
    logic [7:0]      nerr_out;
    logic            fail_out, busy_out, proto_err_out;

    logic [BITS-1:0] d [W];
    logic [BITS-1:0] nd [W];
    logic [BITS-1:0] e [W];
    logic [BITS-1:0] exp_w [W];
    int              exp_nerr;
    logic            exp_fail;
    int              n_cmp = 0;
    int              n_bad = 0;

    nuc970_correct #(.DATA_BITS(DATA_BITS), .BITS(BITS), .T(T)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .start_in(start_in),
        .err_in(err_in), .err_first_in(err_first_in), .err_cnt_in(err_cnt_in),
        .data_out(data_out), .valid_out(valid_out), .first_out(first_out),
        .last_out(last_out), .nerr_out(nerr_out), .fail_out(fail_out),
        .busy_out(busy_out), .proto_err_out(proto_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Codeword is a serial bit stream, MSB of word 0 first; bits past DATA_BITS are padding.
    function automatic int model_total();
        int tot = 0;
        for (int b = 0; b < W * BITS; b++) begin
            if (b < DATA_BITS) tot += int'(e[b / BITS][BITS - 1 - (b % BITS)]);
        end
        return tot;
    endfunction

    task automatic build_expect(input int cnt);
        int tot;
        for (int b = 0; b < W * BITS; b++) begin
            if (b < DATA_BITS)
                exp_w[b / BITS][BITS - 1 - (b % BITS)] = d[b / BITS][BITS - 1 - (b % BITS)] ^ e[b / BITS][BITS - 1 - (b % BITS)];
            else
                exp_w[b / BITS][BITS - 1 - (b % BITS)] = 1'b0;
        end
        tot      = model_total();
        exp_nerr = (tot > 255) ? 255 : tot;
        exp_fail = (exp_nerr != cnt) || (cnt > T);
    endtask

    task automatic send_data(input int s, input int glitch);
        for (int k = s; k < W; k++) begin
            @(posedge clk_in); #1;
            start_in = ((k == 0) || (k == glitch)) ? 1'b1 : 1'b0;
            data_in  = d[k];
        end
    endtask

    task automatic run_err(input int cnt, input int abort_k, input bit overlap);
        build_expect(cnt);
        for (int k = 0; k <= W; k++) begin
            @(posedge clk_in); #1;
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check("abort_outs", {data_out, valid_out, first_out, last_out, nerr_out,
                                     fail_out, busy_out, proto_err_out}, 32'd0);
                @(posedge clk_in); #1;
                check("abort_valid_next", {31'd0, valid_out}, 32'd0);
                check("abort_busy_next", {31'd0, busy_out}, 32'd0);
                err_first_in = 1'b0;
                err_in       = '0;
                rst_n        = 1'b1;
                return;
            end
            if (k > 0) begin
                check("valid", {31'd0, valid_out}, 32'd1);
                check("data", {24'd0, data_out}, {24'd0, exp_w[k - 1]});
                check("first", {31'd0, first_out}, (k == 1) ? 32'd1 : 32'd0);
                check("last", {31'd0, last_out}, (k == W) ? 32'd1 : 32'd0);
                if (k == W) begin
                    check("nerr", {24'd0, nerr_out}, 32'(exp_nerr));
                    check("fail", {31'd0, fail_out}, {31'd0, exp_fail});
                end
            end
            start_in = 1'b0;
            if (k < W) begin
                err_in       = e[k];
                err_first_in = (k == 0) ? 1'b1 : 1'b0;
                err_cnt_in   = (k == 0) ? 8'(cnt) : 8'($urandom_range(0, 255));
            end else begin
                err_in       = '0;
                err_first_in = 1'b0;
            end
            if ((k == W) && overlap) begin
                start_in = 1'b1;
                data_in  = nd[0];
            end
        end
        if (!overlap) begin
            repeat (3) @(posedge clk_in);
            #1;
            check("valid_after", {31'd0, valid_out}, 32'd0);
            check("busy_idle", {31'd0, busy_out}, 32'd0);
            check("nerr_hold", {24'd0, nerr_out}, 32'(exp_nerr));
            check("fail_hold", {31'd0, fail_out}, {31'd0, exp_fail});
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < W; k++) d[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic clear_err();
        for (int k = 0; k < W; k++) e[k] = '0;
    endtask

    task automatic rand_errs(input int n);
        int b;
        clear_err();
        for (int i = 0; i < n; i++) begin
            b = $urandom_range(0, W * BITS - 1);
            e[b / BITS][BITS - 1 - (b % BITS)] = 1'b1;
        end
    endtask

    initial begin
        int cnt;
        // Reset state.
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_flags", {first_out, last_out, fail_out, busy_out, proto_err_out}, 32'd0);
        check("rst_nerr", {24'd0, nerr_out}, 32'd0);
        rst_n = 1'b1;

        // Clean all-ones frame: last word shows padding zeroed.
        for (int k = 0; k < W; k++) d[k] = 8'hFF;
        clear_err();
        send_data(0, -1);
        check("busy_wait", {31'd0, busy_out}, 32'd1);
        run_err(0, -1, 1'b0);
        check("clean_last_word", {24'd0, exp_w[W - 1]}, 32'hF0);

        // Four errors across three words.
        rand_data();
        clear_err();
        e[504] = 8'h24; e[293] = 8'h10; e[168] = 8'h10;
        send_data(0, -1);
        repeat (2) @(posedge clk_in);
        run_err(4, -1, 1'b0);

        // Single flipped bit but decoder claims two.
        rand_data();
        rand_errs(0);
        e[$urandom_range(0, W - 2)][$urandom_range(0, BITS - 1)] = 1'b1;
        send_data(0, -1);
        run_err(2, -1, 1'b0);

        // No flips, decoder claims five.
        rand_data();
        clear_err();
        send_data(0, -1);
        run_err(5, -1, 1'b0);

        // Five consistent flips exceed T; then flips only in padding bits.
        rand_data();
        clear_err();
        e[3] = 8'h1F;
        send_data(0, -1);
        run_err(5, -1, 1'b0);
        rand_data();
        clear_err();
        e[W - 1] = 8'h0F;
        send_data(0, -1);
        run_err(0, -1, 1'b0);

        // Protocol: stray start during capture, stray err_first in idle.
        check("proto_clear", {31'd0, proto_err_out}, 32'd0);
        rand_data();
        rand_errs(3);
        send_data(0, 10);
        @(posedge clk_in); #1;
        check("proto_set", {31'd0, proto_err_out}, 32'd1);
        run_err(model_total(), -1, 1'b0);
        @(posedge clk_in); #1;
        err_first_in = 1'b1;
        err_in       = 8'hFF;
        @(posedge clk_in); #1;
        err_first_in = 1'b0;
        err_in       = '0;
        @(posedge clk_in); #1;
        check("proto_idle_valid", {31'd0, valid_out}, 32'd0);
        check("proto_idle_busy", {31'd0, busy_out}, 32'd0);
        check("proto_sticky", {31'd0, proto_err_out}, 32'd1);

        // Back-to-back: next start coincides with last_out.
        rand_data();
        rand_errs(2);
        for (int k = 0; k < W; k++) nd[k] = 8'($urandom_range(0, 255));
        send_data(0, -1);
        run_err(model_total(), -1, 1'b1);
        for (int k = 0; k < W; k++) d[k] = nd[k];
        rand_errs(4);
        send_data(1, -1);
        run_err(model_total(), -1, 1'b0);

        // Randomized frames with random gaps and counts.
        for (int f = 0; f < 3; f++) begin
            rand_data();
            rand_errs($urandom_range(0, 6));
            cnt = ($urandom_range(0, 1) == 1) ? model_total() : $urandom_range(0, 7);
            send_data(0, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk_in);
            run_err(cnt, -1, 1'b0);
        end

        // Reset while correcting word 100, then a normal frame.
        rand_data();
        rand_errs(2);
        send_data(0, -1);
        run_err(model_total(), 100, 1'b0);
        check("post_abort_proto", {31'd0, proto_err_out}, 32'd0);
        rand_data();
        rand_errs(3);
        send_data(0, -1);
        run_err(model_total(), -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
